rv64_decode_execute: RTL and testbench

- Combined decode/control/execute slice of the RV64I core. Sits between Fetch and RegisterFile.
- Decodes a 32-bit instruction combinationally, drives register-file read addresses and computes the ALU result.
- Presents the result and control signals through a single ID/EX-out pipeline register.
- Memory access, branch resolution and PC redirect are outside this block.

---
 rtl/rv64_decode_execute.sv | 217 +++++++++++++++++++++
 tb/tb_rv64_decode_execute.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv64_decode_execute.sv
// rv64_decode_execute
// Decode/control/execute slice of the RV64I core. It decodes one 32-bit
// instruction combinationally, presents the register-file read addresses,
// computes the ALU result and registers everything into one ID/EX-out stage.
//
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   in_valid, instr, pc fetched instruction and its address
//   rs1_data, rs2_data  register-file read data
//   rs1_addr, rs2_addr  register-file read addresses (combinational)
//   ex_*                registered result and control for the next stage
module rv64_decode_execute #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic [4:0]            rs1_addr,
  output logic [4:0]            rs2_addr,
  output logic                  ex_valid,
  output logic [4:0]            ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [DATA_WIDTH-1:0] ex_store_data,
  output logic [DATA_WIDTH-1:0] ex_result,
  output logic                  ex_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL  = 4'd2,  ALU_SLT    = 4'd3,
    ALU_SLTU = 4'd4,  ALU_XOR  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA    = 4'd7,
    ALU_OR   = 4'd8,  ALU_AND  = 4'd9,  ALU_ADDW = 4'd10, ALU_SUBW   = 4'd11,
    ALU_SLLW = 4'd12, ALU_SRLW = 4'd13, ALU_SRAW = 4'd14, ALU_PASS_B = 4'd15
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP_32  = 7'b0111011;
  localparam logic [6:0] OPC_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // alt selects SUB (funct3 000) or SRA (funct3 101); ignored otherwise.
  function automatic alu_op_t alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_t alu_word(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUBW : ALU_ADDW;
      3'b001:  return ALU_SLLW;
      default: return alt ? ALU_SRAW : ALU_SRLW;
    endcase
  endfunction

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [4:0]            rd;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_u;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd       = instr[11:7];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign imm_i    = {{52{instr[31]}}, instr[31:20]};
  assign imm_s    = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u    = {{32{instr[31]}}, instr[31:12], 12'b0};

  alu_op_t               alu_op;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic                  writes_rd, mem_read, mem_write, illegal, reg_write;

  always_comb begin
    alu_op    = ALU_ADD;
    op_a      = rs1_data;
    op_b      = rs2_data;
    writes_rd = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        writes_rd = 1'b1;
        if (funct7 == 7'b0000000)
          alu_op = alu_base(funct3, 1'b0);
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          alu_op = alu_base(funct3, 1'b1);
        else
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        writes_rd = 1'b1;
        op_b      = imm_i;
        alu_op    = alu_base(funct3, funct3 == 3'b101 && instr[30]);
      end
      OPC_OP_32: begin
        writes_rd = 1'b1;
        if ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101)) ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
          alu_op = alu_word(funct3, funct7[5]);
        else
          illegal = 1'b1;
      end
      OPC_IMM_32: begin
        writes_rd = 1'b1;
        op_b      = imm_i;
        // ADDIW has no funct7; the shift forms still qualify instr[31:25].
        if (funct3 == 3'b000 || (funct3 == 3'b001 && funct7 == 7'b0000000) ||
            (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)))
          alu_op = alu_word(funct3, funct3 == 3'b101 && funct7[5]);
        else
          illegal = 1'b1;
      end
      OPC_LUI: begin
        writes_rd = 1'b1;
        alu_op    = ALU_PASS_B;
        op_b      = imm_u;
      end
      OPC_AUIPC: begin
        writes_rd = 1'b1;
        op_a      = pc;
        op_b      = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        writes_rd = 1'b1;
        op_a      = pc;
        op_b      = 64'd4;
      end
      OPC_LOAD: begin
        writes_rd = 1'b1;
        mem_read  = 1'b1;
        op_b      = imm_i;
      end
      OPC_STORE: begin
        mem_write = 1'b1;
        op_b      = imm_s;
      end
      OPC_BRANCH: ;
      default: illegal = 1'b1;
    endcase
    reg_write = writes_rd && !illegal && (rd != 5'd0);
  end

  logic [DATA_WIDTH-1:0] alu_result;
  logic [31:0]           w_res;

  always_comb begin
    alu_result = '0;
    w_res      = '0;
    case (alu_op)
      ALU_ADD:    alu_result = op_a + op_b;
      ALU_SUB:    alu_result = op_a - op_b;
      ALU_SLL:    alu_result = op_a << op_b[5:0];
      ALU_SLT:    alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   alu_result = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
      ALU_XOR:    alu_result = op_a ^ op_b;
      ALU_SRL:    alu_result = op_a >> op_b[5:0];
      ALU_SRA:    alu_result = $signed(op_a) >>> op_b[5:0];
      ALU_OR:     alu_result = op_a | op_b;
      ALU_AND:    alu_result = op_a & op_b;
      ALU_ADDW:   w_res = op_a[31:0] + op_b[31:0];
      ALU_SUBW:   w_res = op_a[31:0] - op_b[31:0];
      ALU_SLLW:   w_res = op_a[31:0] << op_b[4:0];
      ALU_SRLW:   w_res = op_a[31:0] >> op_b[4:0];
      ALU_SRAW:   w_res = $signed(op_a[31:0]) >>> op_b[4:0];
      default:    alu_result = op_b;
    endcase
    // Word ops produce a 32-bit value that is sign-extended to the datapath.
    if (alu_op >= ALU_ADDW && alu_op != ALU_PASS_B)
      alu_result = {{32{w_res[31]}}, w_res};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_illegal    <= 1'b0;
      ex_store_data <= '0;
      ex_result     <= '0;
    end else begin
      ex_valid      <= in_valid;
      ex_rd         <= rd;
      ex_reg_write  <= in_valid && reg_write;
      ex_mem_read   <= in_valid && mem_read;
      ex_mem_write  <= in_valid && mem_write;
      ex_illegal    <= in_valid && illegal;
      ex_store_data <= rs2_data;
      ex_result     <= alu_result;
    end
  end

endmodule

// File: tb/tb_rv64_decode_execute.sv
// Testbench for rv64_decode_execute: directed and random instructions are
// driven on the falling edge, the expected stage output is queued from a
// reference model, and a monitor pops and compares after each rising edge.
module tb_rv64_decode_execute;

  localparam int N_RAND = 600;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pc = '0, rs1_data = '0, rs2_data = '0;
  logic [4:0]  rs1_addr, rs2_addr, ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
  logic [63:0] ex_store_data, ex_result;

  rv64_decode_execute #(.DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .ex_result(ex_result), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic        reg_write, mem_read, mem_write, illegal;
    logic        chk_result, chk_store;
    logic [63:0] result, store_data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rv_op(input logic [2:0] f3, input logic alt,
                                        input logic [63:0] x, input logic [63:0] y);
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << y[5:0];
      3'd2: return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      3'd3: return (x < y) ? 64'd1 : 64'd0;
      3'd4: return x ^ y;
      3'd5: return alt ? 64'($signed(x) >>> y[5:0]) : x >> y[5:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [63:0] rv_w(input logic [2:0] f3, input logic alt,
                                       input logic [63:0] x, input logic [63:0] y);
    logic [31:0] r;
    case (f3)
      3'd0:    r = alt ? x[31:0] - y[31:0] : x[31:0] + y[31:0];
      3'd1:    r = x[31:0] << y[4:0];
      default: r = alt ? 32'($signed(x[31:0]) >>> y[4:0]) : x[31:0] >> y[4:0];
    endcase
    return {{32{r[31]}}, r};
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [63:0] p,
                                 input logic [63:0] a, input logic [63:0] b, input logic v);
    exp_t e;
    logic [2:0]  f3 = i[14:12];
    logic [6:0]  f7 = i[31:25];
    logic [63:0] imm_i = {{52{i[31]}}, i[31:20]};
    logic [63:0] imm_s = {{52{i[31]}}, i[31:25], i[11:7]};
    logic [63:0] imm_u = {{32{i[31]}}, i[31:12], 12'h000};
    e.valid = v; e.rd = i[11:7];
    e.reg_write = 1'b0; e.mem_read = 1'b0; e.mem_write = 1'b0; e.illegal = 1'b0;
    e.chk_result = 1'b1; e.chk_store = 1'b0; e.result = '0; e.store_data = b;
    case (i[6:0])
      7'h33: begin
        if (f7 == 7'h00) begin e.reg_write = 1; e.result = rv_op(f3, 0, a, b); end
        else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin e.reg_write = 1; e.result = rv_op(f3, 1, a, b); end
        else begin e.illegal = 1; e.chk_result = 0; end
      end
      7'h13: begin e.reg_write = 1; e.result = rv_op(f3, f3 == 5 && i[30], a, imm_i); end
      7'h3B: begin
        if ((f7 == 7'h00 && (f3 == 0 || f3 == 1 || f3 == 5)) || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
          e.reg_write = 1; e.result = rv_w(f3, f7 == 7'h20, a, b);
        end else begin e.illegal = 1; e.chk_result = 0; end
      end
      7'h1B: begin
        if (f3 == 0 || (f3 == 1 && f7 == 7'h00) || (f3 == 5 && (f7 == 7'h00 || f7 == 7'h20))) begin
          e.reg_write = 1; e.result = rv_w(f3, f3 == 5 && f7 == 7'h20, a, imm_i);
        end else begin e.illegal = 1; e.chk_result = 0; end
      end
      7'h37: begin e.reg_write = 1; e.result = imm_u; end
      7'h17: begin e.reg_write = 1; e.result = p + imm_u; end
      7'h6F, 7'h67: begin e.reg_write = 1; e.result = p + 64'd4; end
      7'h03: begin e.reg_write = 1; e.mem_read = 1; e.result = a + imm_i; end
      7'h23: begin e.mem_write = 1; e.chk_store = 1; e.result = a + imm_s; end
      7'h63: e.chk_result = 0;
      default: begin e.illegal = 1; e.chk_result = 0; end
    endcase
    if (e.rd == 5'd0) e.reg_write = 0;
    if (!v) begin
      e.reg_write = 0; e.mem_read = 0; e.mem_write = 0; e.illegal = 0;
      e.chk_result = 0; e.chk_store = 0;
    end
    return e;
  endfunction

  task automatic drive(input logic [31:0] i, input logic [63:0] p,
                       input logic [63:0] a, input logic [63:0] b, input logic v);
    @(negedge clk);
    instr = i; pc = p; rs1_data = a; rs2_data = b; in_valid = v;
    q.push_back(model(i, p, a, b, v));
    mon_en = 1'b1;
    #1;
    check("rs1_addr", 64'(rs1_addr), 64'(i[19:15]));
    check("rs2_addr", 64'(rs2_addr), 64'(i[24:20]));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},      64'(ex_valid), 64'd0);
    check({tag, "_rd"},         64'(ex_rd), 64'd0);
    check({tag, "_reg_write"},  64'(ex_reg_write), 64'd0);
    check({tag, "_mem_read"},   64'(ex_mem_read), 64'd0);
    check({tag, "_mem_write"},  64'(ex_mem_write), 64'd0);
    check({tag, "_illegal"},    64'(ex_illegal), 64'd0);
    check({tag, "_result"},     ex_result, 64'd0);
    check({tag, "_store_data"}, ex_store_data, 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard_empty: got output with no expectation queued");
      end else begin
        mon_e = q.pop_front();
        check("ex_valid", 64'(ex_valid), 64'(mon_e.valid));
        check("ex_reg_write", 64'(ex_reg_write), 64'(mon_e.reg_write));
        check("ex_mem_read", 64'(ex_mem_read), 64'(mon_e.mem_read));
        check("ex_mem_write", 64'(ex_mem_write), 64'(mon_e.mem_write));
        check("ex_illegal", 64'(ex_illegal), 64'(mon_e.illegal));
        if (mon_e.valid) check("ex_rd", 64'(ex_rd), 64'(mon_e.rd));
        if (mon_e.chk_result) check("ex_result", ex_result, mon_e.result);
        if (mon_e.chk_store) check("ex_store_data", ex_store_data, mon_e.store_data);
      end
    end
  end

  function automatic logic [63:0] pick_data();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [11] = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h37, 7'h17,
                               7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};
    logic [31:0] i = $urandom;
    int          sel = $urandom_range(0, 12);
    if (sel < 11) i[6:0] = opcs[sel];
    case ($urandom_range(0, 3))
      0: i[31:25] = 7'h00;
      1: i[31:25] = 7'h20;
      default: ;
    endcase
    return i;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    drive(32'h0050_0093, 64'h100, 64'h1234, 64'h5678, 1'b1);
    drive(32'h4020_81B3, 64'h104, 64'd5, 64'd7, 1'b1);
    drive(32'h1234_52B7, 64'h108, 64'd0, 64'd0, 1'b1);
    drive(32'h0010_809B, 64'h10C, 64'h7FFF_FFFF, 64'd0, 1'b1);
    drive(32'h4040_D113, 64'h110, 64'h8000_0000_0000_0000, 64'd0, 1'b1);
    drive(32'h0020_A423, 64'h114, 64'h1000, 64'hAB, 1'b1);
    drive(32'hFFFF_FFFF, 64'h118, 64'd1, 64'd2, 1'b1);
    drive(32'h0050_0093, 64'h11C, 64'd0, 64'd0, 1'b0);
    drive(32'h0000_006F, 64'h120, 64'd0, 64'd0, 1'b1);
    drive(32'h0000_0093, 64'h124, 64'd9, 64'd0, 1'b1);

    for (int n = 0; n < N_RAND; n++)
      drive(rand_instr(), {$urandom, $urandom}, pick_data(), pick_data(), $urandom_range(0, 4) != 0);

    // Mid-stream reset: an instruction is on the inputs and never emerges.
    drive(32'h0050_0093, 64'h200, 64'd0, 64'd0, 1'b1);
    drive(32'h0070_0113, 64'h204, 64'd0, 64'd0, 1'b1);
    #2;
    mon_en = 1'b0;
    q.delete();
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clk); #1;
    check_zero("reset_hold");
    #1;
    reset = 1'b1;
    #1;
    check_zero("post_release");
    drive(32'h0050_0093, 64'h300, 64'd0, 64'd0, 1'b1);
    for (int n = 0; n < 40; n++)
      drive(rand_instr(), {$urandom, $urandom}, pick_data(), pick_data(), $urandom_range(0, 4) != 0);

    @(posedge clk); #3;
    mon_en = 1'b0;
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
